// File: rtl/nf10_nic_port_lookup.sv
// Output-port lookup: swaps MAC<->DMA bits of the TUSER destination byte on each packet's first beat.
// Define NIC_LOOKUP_DROP_EN to drop packets whose source port byte is not one-hot.
module nf10_nic_port_lookup #(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXI_DATA_WIDTH   = 32
) (
   input  logic                              axi_aclk,
   input  logic                              axi_reset,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic                              s_axis_tlast,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic                              m_axis_tlast,
   input  logic                              rst_cntrs,
   output logic                              pkt_fwd,
   output logic                              pkt_drop,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     pkt_fwd_cntr,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     pkt_drop_cntr
);

   localparam logic [C_S_AXI_DATA_WIDTH-1:0] CNT_ZERO = {C_S_AXI_DATA_WIDTH{1'b0}};
   localparam logic [C_S_AXI_DATA_WIDTH-1:0] CNT_ONE  = {{(C_S_AXI_DATA_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {HEADER = 1'b0, PAYLOAD = 1'b1} state_t;

   state_t                            state_r;
   logic                              drop_r;
   logic                              tvalid_r;
   logic                              tlast_r;
   logic [C_M_AXIS_DATA_WIDTH-1:0]    tdata_r;
   logic [C_M_AXIS_DATA_WIDTH/8-1:0]  tstrb_r;
   logic [C_M_AXIS_TUSER_WIDTH-1:0]   tuser_r;
   logic                              fwd_pulse_r;
   logic                              drop_pulse_r;
   logic [C_S_AXI_DATA_WIDTH-1:0]     fwd_cntr_r;
   logic [C_S_AXI_DATA_WIDTH-1:0]     drop_cntr_r;

   logic [7:0]                        src_s;
   logic                              src_valid_s;
   logic [C_M_AXIS_TUSER_WIDTH-1:0]   tuser_hdr_s;
   logic                              drop_s;
   logic                              accept_s;
   logic                              load_s;
   logic                              fwd_done_s;
   logic                              drop_done_s;

   // Even bits are MAC ports, odd bits DMA ports: swapping each pair maps MAC k <-> DMA k.
   function automatic logic [7:0] swap_pairs(input logic [7:0] port);
      logic [7:0] res;
      for (int k = 0; k < 4; k++) begin
         res[2*k]   = port[2*k+1];
         res[2*k+1] = port[2*k];
      end
      return res;
   endfunction

   function automatic logic is_one_hot(input logic [7:0] port);
      logic [3:0] ones;
      ones = 4'd0;
      for (int b = 0; b < 8; b++) begin
         ones = ones + {3'd0, port[b]};
      end
      return (ones == 4'd1);
   endfunction

   assign s_axis_tready = ~tvalid_r | m_axis_tready;
   assign accept_s      = s_axis_tvalid & s_axis_tready;
   assign load_s        = accept_s & ~drop_s;
   assign fwd_done_s    = accept_s & s_axis_tlast & ~drop_s;
   assign drop_done_s   = accept_s & s_axis_tlast & drop_s;

   // Header rewrite and the drop decision that applies to the beat now on s_axis
   always_comb begin
      src_s       = s_axis_tuser[23:16];
      src_valid_s = is_one_hot(src_s);
      tuser_hdr_s = s_axis_tuser;
      if (src_valid_s) begin
         tuser_hdr_s[31:24] = swap_pairs(src_s);
      end else begin
         tuser_hdr_s[31:24] = 8'h00;
      end
      if (state_r == HEADER) begin
`ifdef NIC_LOOKUP_DROP_EN
         drop_s = ~src_valid_s;
`else
         drop_s = 1'b0;
`endif
      end else begin
         drop_s = drop_r;
      end
   end

   // Packet framing FSM and output valid; the decision is latched on the first beat
   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         state_r  <= HEADER;
         drop_r   <= 1'b0;
         tvalid_r <= 1'b0;
      end else begin
         if (load_s) begin
            tvalid_r <= 1'b1;
         end else if (m_axis_tready) begin
            tvalid_r <= 1'b0;
         end
         if (accept_s) begin
            case (state_r)
               HEADER: begin
                  drop_r  <= drop_s;
                  state_r <= s_axis_tlast ? HEADER : PAYLOAD;
               end
               PAYLOAD: begin
                  state_r <= s_axis_tlast ? HEADER : PAYLOAD;
               end
               default: begin
                  state_r <= HEADER;
               end
            endcase
         end
      end
   end

   // Output data register; contents only matter while tvalid_r is set
   always_ff @(posedge axi_aclk) begin
      if (load_s) begin
         tdata_r <= s_axis_tdata;
         tstrb_r <= s_axis_tstrb;
         tlast_r <= s_axis_tlast;
         tuser_r <= (state_r == HEADER) ? tuser_hdr_s : s_axis_tuser;
      end
   end

   // Packet pulses and counters; rst_cntrs wins over a same-cycle increment
   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         fwd_pulse_r  <= 1'b0;
         drop_pulse_r <= 1'b0;
         fwd_cntr_r   <= CNT_ZERO;
         drop_cntr_r  <= CNT_ZERO;
      end else begin
         fwd_pulse_r  <= fwd_done_s;
         drop_pulse_r <= drop_done_s;
         if (rst_cntrs) begin
            fwd_cntr_r  <= CNT_ZERO;
            drop_cntr_r <= CNT_ZERO;
         end else begin
            if (fwd_done_s) begin
               fwd_cntr_r <= fwd_cntr_r + CNT_ONE;
            end
            if (drop_done_s) begin
               drop_cntr_r <= drop_cntr_r + CNT_ONE;
            end
         end
      end
   end

   assign m_axis_tdata  = tdata_r;
   assign m_axis_tstrb  = tstrb_r;
   assign m_axis_tuser  = tuser_r;
   assign m_axis_tvalid = tvalid_r;
   assign m_axis_tlast  = tlast_r;
   assign pkt_fwd       = fwd_pulse_r;
   assign pkt_drop      = drop_pulse_r;
   assign pkt_fwd_cntr  = fwd_cntr_r;
   assign pkt_drop_cntr = drop_cntr_r;

endmodule

// File: tb/tb_nf10_nic_port_lookup.sv
// Directed bench for nf10_nic_port_lookup; a second instance with 3-bit counters exercises wrap-around.
module tb_nf10_nic_port_lookup;
   localparam int DW = 256;
   localparam int UW = 128;
   localparam int CW = 32;
   localparam logic [95:0]     USER_HI = 96'h0123_4567_89AB_CDEF_0F1E_2D3C;
   localparam logic [DW/8-1:0] STRB    = 32'hFFFF_0001;

   logic axi_aclk = 1'b0;
   always #5 axi_aclk = ~axi_aclk;

   logic            axi_reset, rst_cntrs, m_axis_tready;
   logic            s_axis_tvalid, s_axis_tlast;
   logic [DW-1:0]   s_axis_tdata;
   logic [DW/8-1:0] s_axis_tstrb;
   logic [UW-1:0]   s_axis_tuser;

   logic            s_axis_tready, m_axis_tvalid, m_axis_tlast, pkt_fwd, pkt_drop;
   logic [DW-1:0]   m_axis_tdata;
   logic [DW/8-1:0] m_axis_tstrb;
   logic [UW-1:0]   m_axis_tuser;
   logic [CW-1:0]   pkt_fwd_cntr, pkt_drop_cntr;

   logic            w_s_tready, w_m_tvalid, w_m_tlast, w_pkt_fwd, w_pkt_drop;
   logic [DW-1:0]   w_m_tdata;
   logic [DW/8-1:0] w_m_tstrb;
   logic [UW-1:0]   w_m_tuser;
   logic [2:0]      w_fwd_cntr, w_drop_cntr;

   int n_checks = 0;
   int n_pass   = 0;

   nf10_nic_port_lookup dut (
      .axi_aclk(axi_aclk), .axi_reset(axi_reset),
      .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .rst_cntrs(rst_cntrs), .pkt_fwd(pkt_fwd), .pkt_drop(pkt_drop),
      .pkt_fwd_cntr(pkt_fwd_cntr), .pkt_drop_cntr(pkt_drop_cntr)
   );

   nf10_nic_port_lookup #(.C_S_AXI_DATA_WIDTH(3)) dut_w (
      .axi_aclk(axi_aclk), .axi_reset(axi_reset),
      .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(w_s_tready), .s_axis_tlast(s_axis_tlast),
      .m_axis_tdata(w_m_tdata), .m_axis_tstrb(w_m_tstrb), .m_axis_tuser(w_m_tuser),
      .m_axis_tvalid(w_m_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(w_m_tlast),
      .rst_cntrs(rst_cntrs), .pkt_fwd(w_pkt_fwd), .pkt_drop(w_pkt_drop),
      .pkt_fwd_cntr(w_fwd_cntr), .pkt_drop_cntr(w_drop_cntr)
   );

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk_data(input logic [7:0] id, input logic [7:0] b);
      return {16{id, b}};
   endfunction

   function automatic logic [UW-1:0] mk_user(input logic [7:0] dst, input logic [7:0] src);
      return {USER_HI, dst, src, 16'd64};
   endfunction

   task automatic tick();
      @(posedge axi_aclk);
      #1;
   endtask

   // Every driven beat carries dst byte 8'h5A so rewrites are distinguishable from pass-through.
   task automatic beat(input logic [7:0] id, input logic [7:0] b, input logic [7:0] src, input logic last);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = mk_data(id, b);
      s_axis_tstrb  = STRB;
      s_axis_tuser  = mk_user(8'h5A, src);
      s_axis_tlast  = last;
   endtask

   task automatic idle();
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   initial begin
      axi_reset = 1'b1; rst_cntrs = 1'b0; m_axis_tready = 1'b1;
      s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tuser = '0;
      idle();
      tick(); tick();
      check_eq("rst_tvalid", m_axis_tvalid, 1'b0);
      check_eq("rst_fwd", pkt_fwd, 1'b0);
      check_eq("rst_drop", pkt_drop, 1'b0);
      check_eq("rst_fwd_cntr", pkt_fwd_cntr, 32'h0);
      check_eq("rst_drop_cntr", pkt_drop_cntr, 32'h0);
      axi_reset = 1'b0;

      // single-beat MAC0 -> DMA0
      beat(8'h01, 8'h00, 8'h01, 1'b1); tick();
      check_eq("t1_tvalid", m_axis_tvalid, 1'b1);
      check_eq("t1_tuser", m_axis_tuser, mk_user(8'h02, 8'h01));
      check_eq("t1_tdata", m_axis_tdata, mk_data(8'h01, 8'h00));
      check_eq("t1_tstrb", m_axis_tstrb, STRB);
      check_eq("t1_tlast", m_axis_tlast, 1'b1);
      check_eq("t1_pulse", pkt_fwd, 1'b1);
      check_eq("t1_cntr", pkt_fwd_cntr, 32'h1);
      idle(); tick();
      check_eq("t1_drain", m_axis_tvalid, 1'b0);
      check_eq("t1_pulse_end", pkt_fwd, 1'b0);

      // 4-beat packet with downstream stall while beat 2 is on the output
      rst_cntrs = 1'b1; tick(); rst_cntrs = 1'b0;
      check_eq("rstc_cntr", pkt_fwd_cntr, 32'h0);
      beat(8'h02, 8'h00, 8'h20, 1'b0); tick();
      check_eq("t2_b0_user", m_axis_tuser, mk_user(8'h10, 8'h20));
      check_eq("t2_b0_data", m_axis_tdata, mk_data(8'h02, 8'h00));
      beat(8'h02, 8'h01, 8'h20, 1'b0); tick();
      check_eq("t2_b1_user", m_axis_tuser, mk_user(8'h5A, 8'h20));
      check_eq("t2_b1_data", m_axis_tdata, mk_data(8'h02, 8'h01));
      m_axis_tready = 1'b0;
      beat(8'h02, 8'h02, 8'h20, 1'b0); #1;
      check_eq("t2_stall_rdy", s_axis_tready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("t2_hold_data", m_axis_tdata, mk_data(8'h02, 8'h01));
         check_eq("t2_hold_user", m_axis_tuser, mk_user(8'h5A, 8'h20));
         check_eq("t2_hold_valid", m_axis_tvalid, 1'b1);
         check_eq("t2_hold_rdy", s_axis_tready, 1'b0);
      end
      m_axis_tready = 1'b1; tick();
      check_eq("t2_b2_data", m_axis_tdata, mk_data(8'h02, 8'h02));
      check_eq("t2_b2_last", m_axis_tlast, 1'b0);
      beat(8'h02, 8'h03, 8'h20, 1'b1); tick();
      check_eq("t2_b3_data", m_axis_tdata, mk_data(8'h02, 8'h03));
      check_eq("t2_b3_last", m_axis_tlast, 1'b1);
      check_eq("t2_pulse", pkt_fwd, 1'b1);
      check_eq("t2_cntr", pkt_fwd_cntr, 32'h1);
      idle(); tick();

      // back-to-back packets, no idle cycle
      rst_cntrs = 1'b1; tick(); rst_cntrs = 1'b0;
      beat(8'h03, 8'h00, 8'h04, 1'b0); tick();
      check_eq("t3_a0_user", m_axis_tuser, mk_user(8'h08, 8'h04));
      beat(8'h03, 8'h01, 8'h04, 1'b1); tick();
      check_eq("t3_a1_valid", m_axis_tvalid, 1'b1);
      check_eq("t3_a1_user", m_axis_tuser, mk_user(8'h5A, 8'h04));
      check_eq("t3_a1_cntr", pkt_fwd_cntr, 32'h1);
      beat(8'h04, 8'h00, 8'h80, 1'b1); tick();
      check_eq("t3_b0_valid", m_axis_tvalid, 1'b1);
      check_eq("t3_b0_user", m_axis_tuser, mk_user(8'h40, 8'h80));
      check_eq("t3_b0_data", m_axis_tdata, mk_data(8'h04, 8'h00));
      check_eq("t3_b0_pulse", pkt_fwd, 1'b1);
      check_eq("t3_cntr", pkt_fwd_cntr, 32'h2);
      idle(); tick();
      check_eq("t3_drain", m_axis_tvalid, 1'b0);

      // invalid source (two bits set)
      rst_cntrs = 1'b1; tick(); rst_cntrs = 1'b0;
      beat(8'h05, 8'h00, 8'h03, 1'b0); #1;
      check_eq("t4_rdy", s_axis_tready, 1'b1);
      tick();
`ifdef NIC_LOOKUP_DROP_EN
      check_eq("t4_b0_valid", m_axis_tvalid, 1'b0);
      beat(8'h05, 8'h01, 8'h03, 1'b1); tick();
      check_eq("t4_b1_valid", m_axis_tvalid, 1'b0);
      check_eq("t4_drop_pulse", pkt_drop, 1'b1);
      check_eq("t4_drop_cntr", pkt_drop_cntr, 32'h1);
      check_eq("t4_fwd_cntr", pkt_fwd_cntr, 32'h0);
`else
      check_eq("t4_b0_valid", m_axis_tvalid, 1'b1);
      check_eq("t4_b0_user", m_axis_tuser, mk_user(8'h00, 8'h03));
      beat(8'h05, 8'h01, 8'h03, 1'b1); tick();
      check_eq("t4_b1_user", m_axis_tuser, mk_user(8'h5A, 8'h03));
      check_eq("t4_fwd_pulse", pkt_fwd, 1'b1);
      check_eq("t4_drop_pulse", pkt_drop, 1'b0);
      check_eq("t4_fwd_cntr", pkt_fwd_cntr, 32'h1);
      check_eq("t4_drop_cntr", pkt_drop_cntr, 32'h0);
`endif
      idle(); tick();

      // reset after two beats of a five-beat packet
      beat(8'h06, 8'h00, 8'h01, 1'b0); tick();
      beat(8'h06, 8'h01, 8'h01, 1'b0); tick();
      check_eq("t5_pre_valid", m_axis_tvalid, 1'b1);
      axi_reset = 1'b1; idle(); tick();
      check_eq("t5_rst_valid", m_axis_tvalid, 1'b0);
      check_eq("t5_rst_fwd", pkt_fwd_cntr, 32'h0);
      check_eq("t5_rst_drop", pkt_drop_cntr, 32'h0);
      tick(); axi_reset = 1'b0;
      beat(8'h07, 8'h00, 8'h40, 1'b1); tick();
      check_eq("t5_user", m_axis_tuser, mk_user(8'h80, 8'h40));
      check_eq("t5_valid", m_axis_tvalid, 1'b1);
      check_eq("t5_last", m_axis_tlast, 1'b1);
      check_eq("t5_cntr", pkt_fwd_cntr, 32'h1);
      idle(); tick();

      // rst_cntrs in the same cycle as a tlast acceptance
      beat(8'h08, 8'h00, 8'h02, 1'b1); rst_cntrs = 1'b1; tick(); rst_cntrs = 1'b0;
      check_eq("t6_user", m_axis_tuser, mk_user(8'h01, 8'h02));
      check_eq("t6_cntr", pkt_fwd_cntr, 32'h0);
      check_eq("t6_w_cntr", w_fwd_cntr, 3'h0);

      // wrap of the 3-bit counter instance
      for (int i = 0; i < 7; i++) begin
         beat(8'h09, 8'(i), 8'h08, 1'b1); tick();
      end
      check_eq("t7_w_full", w_fwd_cntr, 3'h7);
      check_eq("t7_cntr7", pkt_fwd_cntr, 32'h7);
      beat(8'h09, 8'h07, 8'h08, 1'b1); tick();
      check_eq("t7_w_wrap", w_fwd_cntr, 3'h0);
      check_eq("t7_cntr8", pkt_fwd_cntr, 32'h8);
      check_eq("t7_w_pulse", w_pkt_fwd, 1'b1);
      check_eq("t7_w_valid", w_m_tvalid, 1'b1);
      check_eq("t7_w_user", w_m_tuser, mk_user(8'h04, 8'h08));
      check_eq("t7_w_data", w_m_tdata, mk_data(8'h09, 8'h07));
      check_eq("t7_w_strb", w_m_tstrb, STRB);
      check_eq("t7_w_last", w_m_tlast, 1'b1);
      check_eq("t7_w_drop", w_pkt_drop, 1'b0);
      check_eq("t7_w_drop_cntr", w_drop_cntr, 3'h0);
      check_eq("t7_w_rdy", w_s_tready, 1'b1);
      idle(); tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
